prio_encoder_rr: RTL and testbench
==================================

# prio_encoder_rr

Parametrised, registered successor to the team's 8-to-3 priority encoder. Takes an N-bit request vector and emits the index and one-hot grant of the winning request through a one-entry valid/ready output register. Selectable per-cycle policy: fixed priority (highest index wins) or round-robin (rotating pointer). Sits between peripheral/request sources and a single consumer in the npc test harness.

## Interface
Parameters:
- `N`, 8, number of request lines; legal range N ≥ 2, need not be a power of two.
- `IDX_W`, `$clog2(N)`, index width; derived localparam, not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  capture enable; 0 blocks new captures, output drains normally.
- `mode`  in  1  0 = fixed priority, 1 = round-robin; sampled on the capture edge.
- `req`  in  N  request vector; bit i = request i.
- `any_req`  out  1  combinational `|req`, independent of `ena` and reset state.
- `out_valid`  out  1  output register holds an unconsumed result.
- `out_ready`  in  1  consumer accepts result when `out_valid & out_ready`.
- `out_idx`  out  IDX_W  winning index.
- `out_grant`  out  N  one-hot of `out_idx`.

## Operation
- Capture condition: `cap = ena & any_req & (~out_valid | out_ready)`.
- Fixed mode: winner = highest set index in `req`.
- RR mode: winner = highest set index ≤ `ptr`; if none, highest set index overall (wrap to N-1 side).
- Internal `ptr` (IDX_W bits), reset N-1. Updated only on an RR-mode capture: `ptr <= (win == 0) ? N-1 : win-1`. Fixed-mode captures and mode switches leave `ptr` untouched.
- On `cap`: `out_idx <= win`, `out_grant <= 1<<win`, `out_valid <= 1`.
- Handshake without capture (`out_valid & out_ready & ~cap`): `out_valid <= 0`; `out_idx`/`out_grant` hold last values.
- Stall (`out_valid & ~out_ready`): all registers incl. `ptr` frozen regardless of `req`, `ena`, `mode`.
- `req` changing or dropping while stalled has no effect on held output; no request memory — a request must be present on the capture edge.
- `ena=0` or `req=0`: no capture; a pending result remains until consumed.
- Non-power-of-two N: `ptr` and `win` never exceed N-1; index bits above N-1 are unreachable.

## Timing
- Reset (`rst_n=0` at edge): `out_valid=0`, `out_idx=0`, `out_grant=0`, `ptr=N-1`. Reset overrides any in-flight handshake.
- Latency: `req` at edge k → result visible after edge k, `out_valid=1` in cycle k+1.
- Throughput: one result per cycle with `out_ready` held high (simultaneous consume + capture replaces result, `out_valid` stays 1).
- `any_req`: zero-cycle combinational.
- First RR capture after reset equals fixed-priority result (ptr=N-1).

## Structure
- Package `prio_enc_pkg`: `MODE_FIXED = 1'b0`, `MODE_RR = 1'b1`.
- Sub-module `prio_find_hi` (parameter N): combinational highest-set-bit finder, outputs `found` and `idx`. Instantiated twice: on `req & mask_le_ptr` and on raw `req`; masked result chosen if found, else raw. Fixed mode uses the raw instance only.
- Top holds `ptr`, output registers, capture/handshake logic.

## Test plan
- Reset: hold `rst_n=0` one edge mid-stall with `out_valid=1` → `out_valid=0`, `out_idx=0`, `out_grant=0`; next RR capture with `req=8'hFF` gives 7.
- Fixed: N=8, mode=0, ena=1, ready=1, `req=8'b0010_0110` held 4 cycles → `out_idx=5`, `out_grant=8'h20` every cycle; `any_req=1`.
- RR full: mode=1, `req=8'hFF` held, ready=1 → `out_idx` 7,6,5,4,3,2,1,0,7.
- RR sparse/wrap: mode=1, `req=8'b1000_0001` → 7,0,7,0; switch to mode=0 mid-sequence → 7,7, back to mode=1 resumes from saved ptr.
- Backpressure: capture idx 5, drop `out_ready` 3 cycles while `req=8'h01` → `out_idx=5`, `out_valid=1`, ptr unchanged; raise ready → next cycle `out_idx=0`.
- Idle/enable: `ena=0`, `req=8'h10` → `any_req=1`, no capture; pending result consumed → `out_valid=0`; `req=0` with ena=1 → `any_req=0`, `out_valid` stays 0. Repeat fixed/RR cases with N=5 to check wrap 0→4.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared policy encodings for the registered round-robin priority encoder.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_find_hi.sv
// Combinational highest-set-bit finder over an N-bit vector.
module prio_find_hi #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Ascending scan: the last hit written is the highest set index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-way priority encoder, fixed or round-robin policy, behind a one-entry
// valid/ready output register.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             mode,
  input  logic [N-1:0]     req,
  output logic             any_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_grant
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     mask_le_ptr;
  logic             m_found, r_found;
  logic [IDX_W-1:0] m_idx, r_idx, win;
  logic             cap;

  always_comb begin
    mask_le_ptr = '0;
    for (int i = 0; i < N; i++) mask_le_ptr[i] = (IDX_W'(i) <= ptr_q);
  end

  prio_find_hi #(.N(N)) u_find_masked (
    .vec_i   (req & mask_le_ptr),
    .found_o (m_found),
    .idx_o   (m_idx)
  );

  prio_find_hi #(.N(N)) u_find_raw (
    .vec_i   (req),
    .found_o (r_found),
    .idx_o   (r_idx)
  );

  // RR falls back to the raw winner when nothing sits at or below ptr (wrap).
  assign win     = (mode == MODE_RR && m_found) ? m_idx : r_idx;
  assign any_req = r_found;
  assign cap     = ena & any_req & (~valid_q | out_ready);

  always_comb begin
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    valid_d = valid_q;
    if (cap) begin
      valid_d = 1'b1;
      idx_d   = win;
      grant_d = N'(1) << win;
      if (mode == MODE_RR)
        ptr_d = (win == '0) ? IDX_W'(N - 1) : win - IDX_W'(1);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= IDX_W'(N - 1);
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_grant = grant_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed scoreboard bench for prio_encoder_rr at N=8 and N=5.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, ena8, mode8, rdy8, any8, vld8;
  logic [7:0] req8, gnt8;
  logic [2:0] idx8;

  logic       rst5_n, ena5, mode5, rdy5, any5, vld5;
  logic [4:0] req5, gnt5;
  logic [2:0] idx5;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .ena(ena8), .mode(mode8), .req(req8),
    .any_req(any8), .out_valid(vld8), .out_ready(rdy8),
    .out_idx(idx8), .out_grant(gnt8)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst5_n), .ena(ena5), .mode(mode5), .req(req5),
    .any_req(any5), .out_valid(vld5), .out_ready(rdy5),
    .out_idx(idx5), .out_grant(gnt5)
  );

  typedef struct {
    string      tag;
    logic       v;
    logic [2:0] idx;
    logic [7:0] g;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on DUT sel (0:N=8, 1:N=5); expected output
  // after the edge is queued now and retired once the edge has happened.
  // rn=0 means reset, so the expected grant is zero rather than 1<<ei.
  task automatic step(input string tag, input bit sel, input logic [7:0] r,
                      input logic m, input logic e, input logic rdy,
                      input logic rn, input logic ev, input int ei);
    exp_t x;
    logic exp_any;
    if (sel) begin
      req5 = r[4:0]; mode5 = m; ena5 = e; rdy5 = rdy; rst5_n = rn;
      exp_any = (r[4:0] != 5'd0);
    end else begin
      req8 = r; mode8 = m; ena8 = e; rdy8 = rdy; rst8_n = rn;
      exp_any = (r != 8'd0);
    end
    x.tag = tag;
    x.v   = ev;
    x.idx = 3'(ei);
    x.g   = rn ? (8'd1 << ei) : 8'd0;
    sbq.push_back(x);
    #1;
    chk({tag, ".any"}, {7'd0, sel ? any5 : any8}, {7'd0, exp_any});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      x = sbq.pop_front();
      chk({x.tag, ".vld"}, {7'd0, sel ? vld5 : vld8}, {7'd0, x.v});
      chk({x.tag, ".idx"}, {5'd0, sel ? idx5 : idx8}, {5'd0, x.idx});
      chk({x.tag, ".gnt"}, sel ? {3'd0, gnt5} : gnt8, x.g);
    end
  endtask

  initial begin
    rst8_n = 1'b0; ena8 = 1'b0; mode8 = 1'b0; rdy8 = 1'b0; req8 = '0;
    rst5_n = 1'b0; ena5 = 1'b0; mode5 = 1'b0; rdy5 = 1'b0; req5 = '0;
    @(posedge clk); #1;

    // ---------------- N = 8 ----------------
    step("rst8_a", 0, 8'h00, 0, 0, 0, 0, 0, 0);
    step("rst8_b", 0, 8'h00, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 4; k++) step("fix8", 0, 8'h26, 0, 1, 1, 1, 1, 5);

    for (int k = 0; k < 9; k++) step("rrfull8", 0, 8'hFF, 1, 1, 1, 1, 1, (k == 8) ? 7 : 7 - k);

    // Backpressure: fixed capture of 5, then stall with req=01 in RR.
    step("bp8_cap", 0, 8'h20, 0, 1, 1, 1, 1, 5);
    for (int k = 0; k < 3; k++) step("bp8_stall", 0, 8'h01, 1, 1, 0, 1, 1, 5);
    step("bp8_rel", 0, 8'h01, 1, 1, 1, 1, 1, 0);
    step("bp8_ptr", 0, 8'hFF, 1, 1, 1, 1, 1, 7);

    // Reset while stalled with valid held, then ptr must be back at N-1.
    step("rst8_stall", 0, 8'hFF, 1, 1, 0, 0, 0, 0);
    step("rst8_rr", 0, 8'hFF, 1, 1, 1, 1, 1, 7);

    step("sp8_0", 0, 8'h81, 1, 1, 1, 1, 1, 0);
    step("sp8_1", 0, 8'h81, 1, 1, 1, 1, 1, 7);
    step("sp8_2", 0, 8'h81, 1, 1, 1, 1, 1, 0);
    step("sp8_3", 0, 8'h81, 1, 1, 1, 1, 1, 7);
    step("sp8_fx0", 0, 8'h81, 0, 1, 1, 1, 1, 7);
    step("sp8_fx1", 0, 8'h81, 0, 1, 1, 1, 1, 7);
    step("sp8_rr0", 0, 8'h81, 1, 1, 1, 1, 1, 0);
    step("sp8_rr1", 0, 8'h81, 1, 1, 1, 1, 1, 7);

    // Idle / enable: pending result held, then drained, no new capture.
    step("ena8_hold", 0, 8'h10, 0, 0, 0, 1, 1, 7);
    step("ena8_drain", 0, 8'h10, 0, 0, 1, 1, 0, 7);
    step("ena8_off", 0, 8'h10, 0, 0, 1, 1, 0, 7);
    step("idle8", 0, 8'h00, 0, 1, 1, 1, 0, 7);

    // ---------------- N = 5 ----------------
    step("rst5", 1, 8'h00, 0, 0, 0, 0, 0, 0);
    step("fix5_a", 1, 8'h16, 0, 1, 1, 1, 1, 4);
    step("fix5_b", 1, 8'h06, 0, 1, 1, 1, 1, 2);
    for (int k = 0; k < 6; k++) step("rrfull5", 1, 8'h1F, 1, 1, 1, 1, 1, (k == 5) ? 4 : 4 - k);
    step("sp5_0", 1, 8'h11, 1, 1, 1, 1, 1, 0);
    step("sp5_1", 1, 8'h11, 1, 1, 1, 1, 1, 4);
    step("sp5_2", 1, 8'h11, 1, 1, 1, 1, 1, 0);
    step("idle5", 1, 8'h00, 1, 1, 1, 1, 0, 0);

    if (sbq.size() != 0) begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
